// File: rtl/iob_2p_ram_be.sv
// iob_2p_ram_be: simple dual-port RAM, one write port with byte strobes,
// one read port with 1- or 2-cycle registered latency and a read-valid flag.
// Optional build macro: IOB_2P_RAM_BE_BYPASS_EN
//   defined   -> write-first forwarding on a same-address read/write collision
//   undefined -> read-first (old contents returned), no bypass muxes
module iob_2p_ram_be #(
  parameter        FILE   = "none",
  parameter int    DATA_W = 32,
  parameter int    ADDR_W = 10,
  parameter int    RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w_en,
  input  logic [DATA_W/8-1:0]      w_strb,
  input  logic [ADDR_W-1:0]        w_addr,
  input  logic [DATA_W-1:0]        w_data,
  input  logic                     r_en,
  input  logic [ADDR_W-1:0]        r_addr,
  output logic [DATA_W-1:0]        r_data,
  output logic                     r_valid
);

  localparam int STRB_W = DATA_W / 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [DATA_W-1:0] rd_word;
  logic              wr_go;
  logic              rd_go;

  // Elaboration-time sanity check of the configuration
  initial begin
    if (RD_LAT != 1 && RD_LAT != 2) begin
      $error("iob_2p_ram_be: RD_LAT must be 1 or 2 (got %0d)", RD_LAT);
      $finish;
    end
    if (DATA_W % 8 != 0 || DATA_W < 8) begin
      $error("iob_2p_ram_be: DATA_W must be a multiple of 8, >= 8 (got %0d)", DATA_W);
      $finish;
    end
  end

  assign wr_go = w_en & ~rst;
  assign rd_go = r_en & ~rst;

  // Array write: only strobed lanes change, contents survive reset
  always_ff @(posedge clk) begin
    if (wr_go) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (w_strb[i]) begin
          mem[w_addr][8*i +: 8] <= w_data[8*i +: 8];
        end
      end
    end
  end

  // Word presented to the read pipeline, with optional same-edge forwarding
  always_comb begin
    rd_word = mem[r_addr];
`ifdef IOB_2P_RAM_BE_BYPASS_EN
    if (w_en && (w_addr == r_addr)) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (w_strb[i]) begin
          rd_word[8*i +: 8] = w_data[8*i +: 8];
        end
      end
    end
`endif
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] s1_data;
      logic              s1_valid;

      // Stage 1 captures the array word; a reset drops anything in flight
      always_ff @(posedge clk) begin
        if (rst) begin
          s1_data  <= '0;
          s1_valid <= 1'b0;
        end else begin
          s1_valid <= rd_go;
          if (rd_go) begin
            s1_data <= rd_word;
          end
        end
      end

      // Output stage forwards stage 1 and holds r_data between reads
      always_ff @(posedge clk) begin
        if (rst) begin
          r_data  <= '0;
          r_valid <= 1'b0;
        end else begin
          r_valid <= s1_valid;
          if (s1_valid) begin
            r_data <= s1_data;
          end
        end
      end
    end else begin : g_lat1
      // Single output register loaded straight from the array
      always_ff @(posedge clk) begin
        if (rst) begin
          r_data  <= '0;
          r_valid <= 1'b0;
        end else begin
          r_valid <= rd_go;
          if (rd_go) begin
            r_data <= rd_word;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_iob_2p_ram_be.sv
// tb_iob_2p_ram_be: directed vectors against two instances (RD_LAT=1 and 2)
// sharing the same stimulus; expected values are hand-computed constants.
module tb_iob_2p_ram_be;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        w_en = 1'b0;
  logic [3:0]  w_strb = '0;
  logic [9:0]  w_addr = '0;
  logic [31:0] w_data = '0;
  logic        r_en = 1'b0;
  logic [9:0]  r_addr = '0;
  logic [31:0] r_data1, r_data2;
  logic        r_valid1, r_valid2;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] collide_exp;

  iob_2p_ram_be #(.FILE("none"), .DATA_W(32), .ADDR_W(10), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .w_en(w_en), .w_strb(w_strb), .w_addr(w_addr),
    .w_data(w_data), .r_en(r_en), .r_addr(r_addr), .r_data(r_data1), .r_valid(r_valid1)
  );

  iob_2p_ram_be #(.FILE("none"), .DATA_W(32), .ADDR_W(10), .RD_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .w_en(w_en), .w_strb(w_strb), .w_addr(w_addr),
    .w_data(w_data), .r_en(r_en), .r_addr(r_addr), .r_data(r_data2), .r_valid(r_valid2)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %08h, expected %08h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, clock it, and return 1 ns after the edge
  task automatic applyStimulus(input logic we, input logic [3:0] strb, input logic [9:0] wa,
                               input logic [31:0] wd, input logic re, input logic [9:0] ra);
    w_en = we; w_strb = strb; w_addr = wa; w_data = wd;
    r_en = re; r_addr = ra;
    @(posedge clk);
    #1;
    w_en = 1'b0; r_en = 1'b0; w_strb = '0;
  endtask

  // Single read checked on both latencies
  task automatic readBoth(input string tag, input logic [9:0] ra, input logic [31:0] exp);
    applyStimulus(1'b0, 4'h0, '0, '0, 1'b1, ra);
    checkOutput({tag, "_l1_valid"}, {31'b0, r_valid1}, 32'd1);
    checkOutput({tag, "_l1_data"}, r_data1, exp);
    checkOutput({tag, "_l2_early"}, {31'b0, r_valid2}, 32'd0);
    applyStimulus(1'b0, 4'h0, '0, '0, 1'b0, '0);
    checkOutput({tag, "_l1_drop"}, {31'b0, r_valid1}, 32'd0);
    checkOutput({tag, "_l2_valid"}, {31'b0, r_valid2}, 32'd1);
    checkOutput({tag, "_l2_data"}, r_data2, exp);
    applyStimulus(1'b0, 4'h0, '0, '0, 1'b0, '0);
    checkOutput({tag, "_l2_drop"}, {31'b0, r_valid2}, 32'd0);
  endtask

  initial begin
    #2;
    // Reset for 3 cycles with r_en held high
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 4'h0, '0, '0, 1'b1, 10'd3);
      checkOutput("rst_l1_valid", {31'b0, r_valid1}, 32'd0);
      checkOutput("rst_l1_data", r_data1, 32'd0);
      checkOutput("rst_l2_valid", {31'b0, r_valid2}, 32'd0);
      checkOutput("rst_l2_data", r_data2, 32'd0);
    end
    rst = 1'b0;
    applyStimulus(1'b0, 4'h0, '0, '0, 1'b0, '0);
    checkOutput("post_rst_l1_valid", {31'b0, r_valid1}, 32'd0);
    checkOutput("post_rst_l2_valid", {31'b0, r_valid2}, 32'd0);

    // Full-word write and readback
    applyStimulus(1'b1, 4'hF, 10'd5, 32'hDEADBEEF, 1'b0, '0);
    readBoth("full_word", 10'd5, 32'hDEADBEEF);

    // Partial-lane write merges with the old word; strb=0 is a no-op
    applyStimulus(1'b1, 4'hF, 10'd7, 32'h11223344, 1'b0, '0);
    applyStimulus(1'b1, 4'b0101, 10'd7, 32'hAABBCCDD, 1'b0, '0);
    readBoth("byte_merge", 10'd7, 32'h11BB33DD);
    applyStimulus(1'b1, 4'h0, 10'd7, 32'h99999999, 1'b0, '0);
    readBoth("strb_zero", 10'd7, 32'h11BB33DD);

    // Same-edge collision on addr 9
    applyStimulus(1'b1, 4'hF, 10'd9, 32'h00000000, 1'b0, '0);
`ifdef IOB_2P_RAM_BE_BYPASS_EN
    collide_exp = 32'h0000F00D;
`else
    collide_exp = 32'h00000000;
`endif
    applyStimulus(1'b1, 4'b0011, 10'd9, 32'hCAFEF00D, 1'b1, 10'd9);
    checkOutput("collide_l1", r_data1, collide_exp);
    applyStimulus(1'b0, 4'h0, '0, '0, 1'b0, '0);
    checkOutput("collide_l2", r_data2, collide_exp);
    readBoth("after_collide", 10'd9, 32'h0000F00D);

    // Write right after a read must not disturb that read's data
    applyStimulus(1'b0, 4'h0, '0, '0, 1'b1, 10'd5);
    applyStimulus(1'b1, 4'hF, 10'd5, 32'h12345678, 1'b0, '0);
    checkOutput("rd_then_wr_l1", r_data1, 32'hDEADBEEF);
    checkOutput("rd_then_wr_l2", r_data2, 32'hDEADBEEF);

    // Fill 0..15 with value=addr, then stream 16 back-to-back reads
    for (int a = 0; a < 16; a++) begin
      applyStimulus(1'b1, 4'hF, 10'(a), 32'(a), 1'b0, '0);
    end
    for (int a = 0; a < 16; a++) begin
      applyStimulus(1'b0, 4'h0, '0, '0, 1'b1, 10'(a));
      checkOutput("stream_l1_valid", {31'b0, r_valid1}, 32'd1);
      checkOutput("stream_l1_data", r_data1, 32'(a));
      if (a > 0) begin
        checkOutput("stream_l2_valid", {31'b0, r_valid2}, 32'd1);
        checkOutput("stream_l2_data", r_data2, 32'(a - 1));
      end
    end
    applyStimulus(1'b0, 4'h0, '0, '0, 1'b0, '0);
    checkOutput("stream_l1_idle", {31'b0, r_valid1}, 32'd0);
    checkOutput("stream_l1_hold", r_data1, 32'd15);
    checkOutput("stream_l2_last_valid", {31'b0, r_valid2}, 32'd1);
    checkOutput("stream_l2_last", r_data2, 32'd15);
    applyStimulus(1'b0, 4'h0, '0, '0, 1'b0, '0);
    checkOutput("stream_l2_idle", {31'b0, r_valid2}, 32'd0);
    checkOutput("stream_l2_hold", r_data2, 32'd15);

    // Reset while a 2-cycle read is still in stage 1: read of addr 1 is in
    // flight when rst arrives together with the request for addr 2
    applyStimulus(1'b0, 4'h0, '0, '0, 1'b1, 10'd1);
    rst = 1'b1;
    applyStimulus(1'b0, 4'h0, '0, '0, 1'b1, 10'd2);
    checkOutput("flush_l2_valid_a", {31'b0, r_valid2}, 32'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 4'h0, '0, '0, 1'b0, '0);
    checkOutput("flush_l2_valid_b", {31'b0, r_valid2}, 32'd0);
    checkOutput("flush_l1_valid", {31'b0, r_valid1}, 32'd0);
    applyStimulus(1'b0, 4'h0, '0, '0, 1'b0, '0);
    checkOutput("flush_l2_valid_c", {31'b0, r_valid2}, 32'd0);
    checkOutput("flush_l2_data", r_data2, 32'd0);
    readBoth("mem_kept", 10'd1, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
